// File: rtl/tiny1_uart_pkg.sv
// Shared constants and types for the tiny1 SoC UART blocks.
package tiny1_uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 104;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous line that idles high.
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Capture the asynchronous input and let it settle for one extra cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: LSB first, idle-high line, valid/ack byte handshake.
module uart_rx_core
  import tiny1_uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  localparam int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ack,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  rx_state_e            state_r;
  rx_state_e            next_state_s;
  logic                 rx2_s;
  logic [CNT_W-1:0]     cnt_r;
  logic [2:0]           idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 load_pend_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 half_tick_s;
  logic                 bit_tick_s;
  logic                 shift_en_s;
  logic                 load_s;
  logic                 ferr_s;
  logic                 state_chg_s;

  uart_sync2 u_sync (
    .clk (clk),
    .rst (rst),
    .d   (RXD),
    .q   (rx2_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RX_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      RX_IDLE: begin
        if (!rx2_s) next_state_s = RX_START;
        else        next_state_s = RX_IDLE;
      end
      RX_START: begin
        if (half_tick_s) next_state_s = rx2_s ? RX_IDLE : RX_DATA;
        else             next_state_s = RX_START;
      end
      RX_DATA: begin
        if (bit_tick_s && (idx_r == 3'd7)) next_state_s = RX_STOP;
        else                               next_state_s = RX_DATA;
      end
      RX_STOP: begin
        if (bit_tick_s) next_state_s = rx2_s ? RX_IDLE : RX_BREAK;
        else            next_state_s = RX_STOP;
      end
      RX_BREAK: begin
        if (rx2_s) next_state_s = RX_IDLE;
        else       next_state_s = RX_BREAK;
      end
      default: next_state_s = RX_IDLE;
    endcase
  end

  // Sample strobes derived from state and bit timer.
  always_comb begin
    half_tick_s = (state_r == RX_START) && (cnt_r == CNT_W'(HALF_BIT - 1));
    bit_tick_s  = ((state_r == RX_DATA) || (state_r == RX_STOP)) &&
                  (cnt_r == CNT_W'(CLKS_PER_BIT - 1));
    shift_en_s  = bit_tick_s && (state_r == RX_DATA);
    load_s      = bit_tick_s && (state_r == RX_STOP) && rx2_s;
    ferr_s      = bit_tick_s && (state_r == RX_STOP) && !rx2_s;
    state_chg_s = (next_state_s != state_r);
  end

  // Bit timer and bit index; cleared on every state change and every data sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      idx_r <= 3'd0;
    end else begin
      if (state_chg_s || bit_tick_s) begin
        cnt_r <= '0;
      end else if ((state_r == RX_START) || (state_r == RX_DATA) || (state_r == RX_STOP)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= '0;
      end
      if (state_chg_s) begin
        idx_r <= 3'd0;
      end else if (shift_en_s) begin
        idx_r <= idx_r + 3'd1;
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  // Receive shift register and the one-cycle delayed byte load.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r     <= '0;
      load_pend_r <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      if (shift_en_s) begin
        shift_r <= {rx2_s, shift_r[DATA_BITS-1:1]};
      end else begin
        shift_r <= shift_r;
      end
      load_pend_r <= load_s;
      frame_err_r <= ferr_s;
    end
  end

  // Output byte, valid/ack handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= '0;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else if (load_pend_r) begin
      // A same-cycle ack consumes the old byte, so the new one is not an overrun.
      data_r    <= shift_r;
      valid_r   <= 1'b1;
      overrun_r <= (valid_r && ack) ? 1'b0 : (overrun_r || valid_r);
    end else if (valid_r && ack) begin
      data_r    <= data_r;
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      data_r    <= data_r;
      valid_r   <= valid_r;
      overrun_r <= overrun_r;
    end
  end

  assign data      = data_r;
  assign valid     = valid_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with an event-schedule reference model.
module tb_uart_rx_core;

  localparam int CPB  = 16;
  localparam int LAT  = 3 + CPB / 2 + 9 * CPB;  // start edge -> valid rise
  localparam int FLAT = LAT - 1;                // start edge -> stop-bit sample

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .RXD       (rxd),
    .data      (data),
    .valid     (valid),
    .ack       (ack),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    bit         is_ferr;
    logic [7:0] b;
  } ev_t;

  ev_t        evq[$];
  ev_t        ev_m;
  int         cyc = 0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic       exp_ferr = 1'b0;
  logic       exp_ovr = 1'b0;

  // Reference model: apply scheduled byte/error events and the handshake rules per edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    exp_ferr = 1'b0;
    if (rst) begin
      exp_data = 8'h00;
      exp_valid = 1'b0;
      exp_ovr = 1'b0;
      evq.delete();
    end else begin
      if (evq.size() > 0 && evq[0].t == cyc) begin
        ev_m = evq.pop_front();
        if (ev_m.is_ferr) begin
          exp_ferr = 1'b1;
          if (ack && exp_valid) begin
            exp_valid = 1'b0;
            exp_ovr = 1'b0;
          end
        end else begin
          exp_ovr = (ack && exp_valid) ? 1'b0 : (exp_ovr | exp_valid);
          exp_data = ev_m.b;
          exp_valid = 1'b1;
        end
      end else if (ack && exp_valid) begin
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
      end
    end
  end

  int   cmp_m = 0, mis_m = 0;
  int   cmp_l = 0, mis_l = 0;
  bit   cmp_en = 1'b0;
  logic valid_q = 1'b0;
  int   last_rise = -1;
  int   ferr_cnt = 0;

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_m = cmp_m + 4;
      if (data !== exp_data) begin
        mis_m = mis_m + 1;
        $display("FAIL model_data cyc=%0d got=%h want=%h", cyc, data, exp_data);
      end
      if (valid !== exp_valid) begin
        mis_m = mis_m + 1;
        $display("FAIL model_valid cyc=%0d got=%b want=%b", cyc, valid, exp_valid);
      end
      if (frame_err !== exp_ferr) begin
        mis_m = mis_m + 1;
        $display("FAIL model_frame_err cyc=%0d got=%b want=%b", cyc, frame_err, exp_ferr);
      end
      if (overrun !== exp_ovr) begin
        mis_m = mis_m + 1;
        $display("FAIL model_overrun cyc=%0d got=%b want=%b", cyc, overrun, exp_ovr);
      end
      if (valid === 1'b1 && valid_q === 1'b0) last_rise = cyc;
      valid_q = valid;
      if (frame_err === 1'b1) ferr_cnt = ferr_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    cmp_l = cmp_l + 1;
    if (act !== req) begin
      mis_l = mis_l + 1;
      $display("FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  // Drive one full frame; returns the clk edge at which the start bit is first sampled.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int e);
    ev_t ev;
    e = cyc + 1;
    ev.b = b;
    ev.is_ferr = !stop;
    ev.t = stop ? (e + LAT) : (e + FLAT);
    evq.push_back(ev);
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick(CPB);
    end
    rxd = stop;
    tick(CPB);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  int e0, e1, eb, f0;
  logic [7:0] pb;

  initial begin
    rst = 1'b1;
    tick(1);
    cmp_en = 1'b1;
    tick(2);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 0);
    rst = 1'b0;
    tick(20);

    // Clean 0x55 frame, exact latency, then ack.
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b1, e0);
    tick(CPB);
    check("lat_55", last_rise - e0, 155);
    check("data_55", data, 8'h55);
    check("ferr_55", ferr_cnt - f0, 0);
    check("ovr_55", overrun, 0);
    do_ack();
    check("ack_55_valid", valid, 0);

    // Short low glitch, then a clean frame.
    f0 = ferr_cnt;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    tick(3 * CPB);
    check("glitch_valid", valid, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    send_frame(8'hC3, 1'b1, e0);
    tick(CPB);
    check("data_c3", data, 8'hC3);
    do_ack();

    // Bad stop bit followed by a long break, then recovery.
    f0 = ferr_cnt;
    send_frame(8'hA3, 1'b0, e0);
    tick(40 * CPB);
    rxd = 1'b1;
    tick(2 * CPB);
    check("break_ferr_pulses", ferr_cnt - f0, 1);
    check("break_valid", valid, 0);
    check("break_data_kept", data, 8'hC3);
    send_frame(8'h3C, 1'b1, e0);
    tick(CPB);
    check("data_3c", data, 8'h3C);
    check("valid_3c", valid, 1);
    do_ack();

    // Back-to-back frames without ack.
    send_frame(8'h01, 1'b1, e0);
    send_frame(8'hFF, 1'b1, e1);
    tick(CPB);
    check("b2b_data", data, 8'hFF);
    check("b2b_valid", valid, 1);
    check("b2b_ovr", overrun, 1);
    do_ack();
    check("b2b_ack_valid", valid, 0);
    check("b2b_ack_ovr", overrun, 0);

    // Ack lands in the exact cycle the second byte loads.
    send_frame(8'h11, 1'b1, e0);
    eb = cyc + 1;
    fork
      send_frame(8'h7E, 1'b1, e1);
      begin
        while (cyc < eb + LAT - 1) tick(1);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
      end
    join
    tick(CPB);
    check("same_ack_valid", valid, 1);
    check("same_ack_data", data, 8'h7E);
    check("same_ack_ovr", overrun, 0);
    do_ack();

    // Reset during data bit 4 with an unread byte pending.
    send_frame(8'h42, 1'b1, e0);
    send_frame(8'h43, 1'b1, e0);
    check("pre_rst_ovr", overrun, 1);
    pb = 8'h96;
    rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rxd = pb[i];
      tick(CPB);
    end
    rxd = pb[4];
    tick(CPB / 2);
    rst = 1'b1;
    rxd = 1'b1;
    tick(1);
    check("rst_data", data, 8'h00);
    check("rst_valid", valid, 0);
    check("rst_ovr", overrun, 0);
    check("rst_ferr", frame_err, 0);
    rst = 1'b0;
    tick(3 * CPB);
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b1, e0);
    tick(CPB);
    check("data_81", data, 8'h81);
    check("valid_81", valid, 1);
    check("ferr_81", ferr_cnt - f0, 0);
    do_ack();
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_m + cmp_l, mis_m + mis_l);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- UART receiver for the tiny1 iCE40 SoC: 8N1, LSB first, line idles high.
- Deserialises the RXD pin into bytes and presents them to the CPU I/O port through a valid/ack handshake.
- Counterpart to the SoC's TXD transmitter. It is also instantiated in benches to decode TXD traffic.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200 baud). Must be an even integer >= 8.
- HALF_BIT, CLKS_PER_BIT/2, start-bit mid-sample offset. Derived; do not override.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- RXD  input  1  serial line; asynchronous to clk; idle high
- data  output  8  last correctly framed byte
- valid  output  1  data holds an unread byte; held until ack
- ack  input  1  consumer has read data; meaningful only while valid=1
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- overrun  output  1  sticky: a byte was overwritten while valid=1; cleared by ack

Behaviour:
- Reset is synchronous: while rst=1 at a clk edge, the following values are loaded.
  - State = IDLE.
  - data=8'h00, valid=0, frame_err=0, overrun=0.
  - Both synchroniser flops = 1.
  - Bit counter and bit index = 0.
  - Reset mid-frame abandons the frame silently.
- Input path: RXD passes through 2 flops (rx1, rx2). All decisions use rx2 only.
- States: IDLE, START, DATA, STOP, BREAK. Counter cnt counts clk cycles; idx counts 0..7.
- IDLE: if rx2=0 -> START, cnt=0.
- START: when cnt==HALF_BIT-1, sample rx2.
  - rx2=0 -> DATA, cnt=0, idx=0.
  - rx2=1 (glitch) -> IDLE, no outputs change.
- DATA: when cnt==CLKS_PER_BIT-1, sample rx2 into shift register MSB and shift right; cnt=0.
  - After the idx=7 sample -> STOP.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx2.
  - rx2=1 -> load data from the shift register, valid=1 next cycle, -> IDLE. The receiver is re-armed half a bit early so back-to-back frames are accepted.
  - rx2=0 -> frame_err=1 for exactly one cycle; data and valid untouched; -> BREAK.
- BREAK: stay until rx2=1, then -> IDLE. A held-low line (break) yields no further bytes or errors.
- Latency: RXD falling edge sampled at clk edge e gives valid rising at edge e+3+HALF_BIT+9*CLKS_PER_BIT. Benches check this exactly.
- Handshake rules:
  - ack with valid=1 and no byte completing -> valid=0 and overrun=0 next cycle.
  - ack while valid=0 is ignored.
- Byte completing while valid=1:
  - ack=0 -> data overwritten, valid stays 1, overrun=1.
  - ack=1 in the same cycle -> new byte wins, valid stays 1, overrun=0.
- frame_err and a valid load never occur in the same cycle.
- Arithmetic: cnt width $clog2(CLKS_PER_BIT); idx 3 bits. Counters never wrap mid-state; they are cleared on every state change.

Decomposition:
- Package tiny1_uart_pkg holds:
  - rx state enum (IDLE, START, DATA, STOP, BREAK).
  - DATA_BITS=8.
  - Default CLKS_PER_BIT=104. The future uart_tx_core shares this constant.
- One sub-module: uart_sync2, a 2-flop synchroniser with reset value 1, clk/rst/d/q.
- Everything else stays in uart_rx_core as a single state machine plus datapath.

Test Plan (CLKS_PER_BIT=16, bench drives RXD with bit period 16 clk):
- Frame 0x55, good stop bit -> data=0x55, valid rises exactly 3+8+144=155 cycles after the start edge; frame_err and overrun stay 0; ack -> valid=0 next cycle.
- RXD low for 4 cycles then high -> no valid, no frame_err; a clean 0xC3 frame afterwards -> data=0xC3.
- Frame 0xA3 with stop bit 0, then line held low 40 bit-times -> one frame_err pulse of 1 cycle; valid stays 0; data keeps its previous value; then line high and frame 0x3C -> data=0x3C, valid=1.
- Back-to-back frames 0x01, 0xFF, no ack -> data=0xFF, valid=1, overrun=1; ack -> valid=0, overrun=0.
- ack asserted in the exact cycle the second byte 0x7E loads -> valid stays 1, data=0x7E, overrun=0.
- rst pulsed during data bit 4 -> next cycle all outputs 0; subsequent clean frame 0x81 -> data=0x81, valid=1, no frame_err.
